bus_loader_arbiter: RTL and testbench
=====================================

Name: bus_loader_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: the 6502 model's bus (cpu_*) and a byte-stream host loader driven from the RS232 receiver.
- Sits between chip_6502 and the block RAM, on eclk.
- Decodes a small host command protocol: write memory, read memory back, hold/release the CPU.
- Drives the CPU reset request, so the host can halt the CPU, load a program, and start it.

Parameters:
- ADDR_W, 16, memory/CPU address width
- HOLD_ON_RESET, 1, cpu_hold value after ereset (1 = CPU held until host issues Go)

Ports:
- eclk  in  1  emulation clock
- ereset  in  1  synchronous active-high reset
- cpu_req  in  1  one-cycle strobe: CPU bus cycle valid this eclk
- cpu_addr  in  ADDR_W  CPU address (ab)
- cpu_rw  in  1  1 = read, 0 = write
- cpu_wdata  in  8  CPU write data (db_o)
- cpu_rdata  out  8  read data to CPU (db_i)
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_hold  out  1  CPU reset request (drives res, inverted externally)
- rx_data  in  8  host byte
- rx_valid  in  1  host byte strobe (no backpressure; at most one per 2 eclk)
- tx_data  out  8  byte to host transmitter
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, valid 1 eclk after address

Behaviour:
- Reset is synchronous, active-high, on eclk. Values after reset:
  - cpu_hold = HOLD_ON_RESET; all other outputs 0.
  - Loader FSM in IDLE; ereset mid-command aborts it and drops any pending tx byte.
- Arbitration: fixed CPU priority.
  - cpu_req=1: mem_addr=cpu_addr, mem_we=~cpu_rw, mem_wdata=cpu_wdata in the same cycle.
  - Read: cpu_rvalid=1 exactly one cycle later, with cpu_rdata=mem_rdata; cpu_rdata holds its value otherwise.
  - The loader gets the memory only in cycles with cpu_req=0.
  - A pending loader access waits; it is never dropped.
- Loader FSM states: IDLE, ADDR_HI, ADDR_LO, COUNT, WDATA, RD_ISSUE, RD_WAIT, TX.
  - IDLE, rx 0x57 'W' or 0x52 'R': latch op, go to ADDR_HI.
  - IDLE, rx 0x48 'H': cpu_hold=1; echo 0x48 via TX.
  - IDLE, rx 0x47 'G': cpu_hold=0; echo 0x47 via TX.
  - IDLE, any other byte: ignored, FSM stays in IDLE.
  - ADDR_HI, then ADDR_LO: capture 16-bit address, big-endian.
  - COUNT: capture count byte; 0 means 256.
    - op W: go to WDATA.
    - op R: go to RD_ISSUE.
  - WDATA: on each rx byte, queue one write (one-byte pending register), address++, count--.
    - Return to IDLE after the last write commits.
    - A second byte arriving while the first is still pending overwrites it; the host protocol forbids this.
  - RD_ISSUE: drive a loader read in the first cycle with cpu_req=0, then RD_WAIT.
  - RD_WAIT: capture mem_rdata one cycle later, go to TX.
  - TX: hold tx_valid=1 until tx_ready. Then address++, count--.
    - count>0: RD_ISSUE.
    - count=0: IDLE.
- Address arithmetic is modulo 2^ADDR_W: FFFF+1 wraps to 0000.
- Count is a 9-bit internal counter.
- Bytes received during RD_*/TX are ignored.
- H/G are accepted only in IDLE.
- A CPU write and a loader write never share a cycle; priority rule applies.

Decomposition:
- Shared package bus_pkg holds:
  - command byte constants CMD_W=8'h57, CMD_R=8'h52, CMD_H=8'h48, CMD_G=8'h47
  - loader state enum
- One natural sub-module, loader_fsm: protocol decode plus address/count registers. It issues req/we/addr/wdata and receives a grant.
- The top level does the priority mux and the CPU read-valid pipeline.

Test Plan:
- Reset with HOLD_ON_RESET=1 -> cpu_hold=1, tx_valid=0, mem_we=0; then rx 0x47 -> cpu_hold=0 and tx byte 0x47.
- rx 57 12 34 03 AA BB CC -> mem writes 1234=AA, 1235=BB, 1236=CC, each exactly once; FSM returns to IDLE.
- Preload 1234..1236; rx 52 12 34 03 with tx_ready random -> tx sequence AA, BB, CC; tx_data stable while tx_valid&~tx_ready.
- Loader write pending while cpu_req asserted for 5 consecutive cycles -> CPU accesses serviced first, each read gets cpu_rvalid exactly 1 cycle later; loader write lands in the 6th cycle.
- rx 57 FF FF 02 11 22 -> FFFF=11, 0000=22 (wrap). rx 52 00 10 00 -> exactly 256 tx bytes.
- ereset asserted after 57 12 -> no memory write occurs; FSM in IDLE; next 0x47 is accepted normally.

Source files
------------

// File: rtl/bus_loader_arbiter_pkg.sv
// Shared constants and types for the CPU/host-loader memory arbiter.
// Host command bytes, loader FSM states and the loader operation kind.
package bus_pkg;

   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] CMD_H = 8'h48;
   localparam logic [7:0] CMD_G = 8'h47;

   typedef enum logic [2:0] {
      IDLE,
      ADDR_HI,
      ADDR_LO,
      COUNT,
      WDATA,
      RD_ISSUE,
      RD_WAIT,
      TX
   } ld_state_t;

   typedef enum logic [1:0] {
      OP_WRITE,
      OP_READ,
      OP_ECHO
   } ld_op_t;

   // A count byte of zero stands for a full 256-byte block.
   function automatic logic [8:0] count_decode(input logic [7:0] b);
      return (b == 8'd0) ? 9'd256 : {1'b0, b};
   endfunction

endpackage

// File: rtl/bus_loader_arbiter_if.sv
// CPU bus, host byte stream and memory port of the loader/arbiter.
// slave = arbiter side, master = surrounding system (CPU, UART, RAM).
interface bus_loader_arbiter_if #(
   parameter int ADDR_W = 16
);
   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_rw;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_rdata;
   logic              cpu_rvalid;
   logic              cpu_hold;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  cpu_req, cpu_addr, cpu_rw, cpu_wdata, rx_data, rx_valid, tx_ready, mem_rdata,
      output cpu_rdata, cpu_rvalid, cpu_hold, tx_data, tx_valid, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output cpu_req, cpu_addr, cpu_rw, cpu_wdata, rx_data, rx_valid, tx_ready, mem_rdata,
      input  cpu_rdata, cpu_rvalid, cpu_hold, tx_data, tx_valid, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/bus_loader_arbiter_loader_fsm.sv
// Host command decoder: W/R block transfers plus H/G CPU hold control; one read in flight,
// one write pending. Requests wait for ld_gnt; tx byte held until tx_ready; rx is never stalled.
module loader_fsm
   import bus_pkg::*;
#(
   parameter int ADDR_W        = 16,
   parameter bit HOLD_ON_RESET = 1'b1
) (
   input  logic              eclk,
   input  logic              ereset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              cpu_hold,
   output logic              ld_req,
   output logic              ld_we,
   output logic [ADDR_W-1:0] ld_addr,
   output logic [7:0]        ld_wdata,
   input  logic              ld_gnt,
   input  logic [7:0]        mem_rdata
);

   ld_state_t         state_q, state_d;
   ld_op_t            op_q, op_d;
   logic [7:0]        addr_hi_q;
   logic [ADDR_W-1:0] addr_q;
   logic [8:0]        cnt_q;
   logic              pend_vld_q;
   logic [ADDR_W-1:0] pend_addr_q;
   logic [7:0]        pend_dat_q;
   logic [7:0]        tx_q;
   logic              hold_q;

   logic latch_op, set_hold, clr_hold, cap_hi, cap_lo, cap_cnt;
   logic wr_queue, rd_cap, tx_done;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      latch_op = 1'b0;
      set_hold = 1'b0;
      clr_hold = 1'b0;
      cap_hi   = 1'b0;
      cap_lo   = 1'b0;
      cap_cnt  = 1'b0;
      wr_queue = 1'b0;
      rd_cap   = 1'b0;
      tx_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               case (rx_data)
                  CMD_W: begin latch_op = 1'b1; op_d = OP_WRITE; state_d = ADDR_HI; end
                  CMD_R: begin latch_op = 1'b1; op_d = OP_READ;  state_d = ADDR_HI; end
                  CMD_H: begin latch_op = 1'b1; op_d = OP_ECHO; set_hold = 1'b1; state_d = TX; end
                  CMD_G: begin latch_op = 1'b1; op_d = OP_ECHO; clr_hold = 1'b1; state_d = TX; end
                  default: ;
               endcase
            end
         end
         ADDR_HI: if (rx_valid) begin cap_hi = 1'b1; state_d = ADDR_LO; end
         ADDR_LO: if (rx_valid) begin cap_lo = 1'b1; state_d = COUNT; end
         COUNT: begin
            if (rx_valid) begin
               cap_cnt = 1'b1;
               state_d = (op_q == OP_WRITE) ? WDATA : RD_ISSUE;
            end
         end
         WDATA: begin
            if (rx_valid && cnt_q != 9'd0) wr_queue = 1'b1;
            // Leave only once the final queued byte has actually reached memory.
            if (cnt_q == 9'd0 && (!pend_vld_q || ld_gnt)) state_d = IDLE;
         end
         RD_ISSUE: if (ld_gnt) state_d = RD_WAIT;
         RD_WAIT: begin rd_cap = 1'b1; state_d = TX; end
         TX: begin
            if (tx_ready) begin
               tx_done = 1'b1;
               if (op_q == OP_ECHO || cnt_q == 9'd1) state_d = IDLE;
               else                                  state_d = RD_ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge eclk) begin
      if (ereset) begin
         state_q     <= IDLE;
         op_q        <= OP_WRITE;
         addr_hi_q   <= 8'd0;
         addr_q      <= '0;
         cnt_q       <= 9'd0;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
         pend_dat_q  <= 8'd0;
         tx_q        <= 8'd0;
         hold_q      <= HOLD_ON_RESET;
      end else begin
         state_q <= state_d;
         if (latch_op) op_q <= op_d;
         if (set_hold) hold_q <= 1'b1;
         if (clr_hold) hold_q <= 1'b0;
         if (set_hold || clr_hold) tx_q <= rx_data;
         if (cap_hi) addr_hi_q <= rx_data;
         if (cap_lo) addr_q <= ADDR_W'({addr_hi_q, rx_data});
         if (cap_cnt) cnt_q <= count_decode(rx_data);
         if (wr_queue) begin
            pend_vld_q  <= 1'b1;
            pend_addr_q <= addr_q;
            pend_dat_q  <= rx_data;
            addr_q      <= addr_q + ADDR_W'(1);
            cnt_q       <= cnt_q - 9'd1;
         end else if (ld_gnt) begin
            pend_vld_q <= 1'b0;
         end
         if (rd_cap) tx_q <= mem_rdata;
         if (tx_done && op_q != OP_ECHO) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q - 9'd1;
         end
      end
   end

   assign ld_req   = pend_vld_q || (state_q == RD_ISSUE);
   assign ld_we    = pend_vld_q;
   assign ld_addr  = pend_vld_q ? pend_addr_q : addr_q;
   assign ld_wdata = pend_dat_q;
   assign tx_valid = (state_q == TX);
   assign tx_data  = tx_q;
   assign cpu_hold = hold_q;

endmodule

// File: rtl/bus_loader_arbiter.sv
// Single-port RAM shared by the CPU (fixed priority, read data 1 eclk after request) and the host loader.
// The CPU is never stalled; loader accesses wait for a cycle with cpu_req low.
module bus_loader_arbiter
   import bus_pkg::*;
#(
   parameter int ADDR_W        = 16,
   parameter bit HOLD_ON_RESET = 1'b1
) (
   input  logic                  eclk,
   input  logic                  ereset,
   bus_loader_arbiter_if.slave   bus
);

   logic              ld_req, ld_we, ld_gnt;
   logic [ADDR_W-1:0] ld_addr;
   logic [7:0]        ld_wdata;
   logic              rvalid_q;
   logic [7:0]        rdata_q;

   loader_fsm #(
      .ADDR_W        (ADDR_W),
      .HOLD_ON_RESET (HOLD_ON_RESET)
   ) u_loader (
      .eclk      (eclk),
      .ereset    (ereset),
      .rx_data   (bus.rx_data),
      .rx_valid  (bus.rx_valid),
      .tx_data   (bus.tx_data),
      .tx_valid  (bus.tx_valid),
      .tx_ready  (bus.tx_ready),
      .cpu_hold  (bus.cpu_hold),
      .ld_req    (ld_req),
      .ld_we     (ld_we),
      .ld_addr   (ld_addr),
      .ld_wdata  (ld_wdata),
      .ld_gnt    (ld_gnt),
      .mem_rdata (bus.mem_rdata)
   );

   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = 8'd0;
      ld_gnt        = 1'b0;
      if (bus.cpu_req) begin
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_we    = ~bus.cpu_rw;
         bus.mem_wdata = bus.cpu_wdata;
      end else if (ld_req) begin
         bus.mem_addr  = ld_addr;
         bus.mem_we    = ld_we;
         bus.mem_wdata = ld_wdata;
         ld_gnt        = 1'b1;
      end
   end

   // RAM output is only meaningful in the cycle after a read, so keep a copy for the CPU.
   always_ff @(posedge eclk) begin
      if (ereset) begin
         rvalid_q <= 1'b0;
         rdata_q  <= 8'd0;
      end else begin
         rvalid_q <= bus.cpu_req & bus.cpu_rw;
         if (rvalid_q) rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.cpu_rvalid = rvalid_q;
   assign bus.cpu_rdata  = rvalid_q ? bus.mem_rdata : rdata_q;

endmodule

// File: tb/tb_bus_loader_arbiter.sv
// Scoreboard bench: stimulus queues expected memory writes, tx bytes and CPU reads;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_bus_loader_arbiter;

   typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
   typedef struct packed { logic [7:0] data; int cyc; } rd_t;

   logic eclk = 1'b0;
   logic ereset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic tx_rand = 1'b0;
   logic [7:0] mem [0:65535];

   wr_t        exp_wr[$];
   logic [7:0] exp_tx[$];
   rd_t        exp_rd[$];

   bus_loader_arbiter_if #(.ADDR_W(16)) bus ();

   bus_loader_arbiter #(.ADDR_W(16), .HOLD_ON_RESET(1'b1)) dut (
      .eclk   (eclk),
      .ereset (ereset),
      .bus    (bus)
   );

   always #5 eclk = ~eclk;
   always @(posedge eclk) cyc <= cyc + 1;

   always @(posedge eclk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      bus.tx_ready = 1'b1;
      forever begin
         @(posedge eclk);
         #1;
         bus.tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   logic       tx_stall_prev = 1'b0;
   logic [7:0] tx_prev = 8'd0;
   always @(negedge eclk) begin
      wr_t w;
      rd_t r;
      logic [7:0] t;
      if (ereset) begin
         tx_stall_prev = 1'b0;
      end else begin
         if (bus.mem_we) begin
            if (exp_wr.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: addr %h data %h, expected no write", bus.mem_addr, bus.mem_wdata);
            end else begin
               w = exp_wr.pop_front();
               check("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
               check("wr_data", 32'(bus.mem_wdata), 32'(w.data));
            end
         end
         if (bus.tx_valid && bus.tx_ready) begin
            if (exp_tx.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_tx: byte %h, expected none", bus.tx_data);
            end else begin
               t = exp_tx.pop_front();
               check("tx_data", 32'(bus.tx_data), 32'(t));
            end
         end
         if (bus.cpu_rvalid) begin
            if (exp_rd.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rvalid: data %h, expected none", bus.cpu_rdata);
            end else begin
               r = exp_rd.pop_front();
               check("cpu_rdata", 32'(bus.cpu_rdata), 32'(r.data));
               check("cpu_rvalid_cycle", 32'(cyc), 32'(r.cyc));
            end
         end
         if (tx_stall_prev) begin
            check("tx_valid_hold", 32'(bus.tx_valid), 32'd1);
            check("tx_data_hold", 32'(bus.tx_data), 32'(tx_prev));
         end
         tx_stall_prev = bus.tx_valid & ~bus.tx_ready;
         tx_prev       = bus.tx_data;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge eclk); #1;
      bus.rx_valid = 1'b0;
      @(posedge eclk); #1;
   endtask

   task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3);
      send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_wr.size() + exp_tx.size() + exp_rd.size()) != 0 && n < 3000) begin
         @(posedge eclk); #1;
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL %s_timeout: %0d expectations left, expected 0", name,
                  exp_wr.size() + exp_tx.size() + exp_rd.size());
         exp_wr.delete(); exp_tx.delete(); exp_rd.delete();
      end
      repeat (4) begin @(posedge eclk); #1; end
   endtask

   task automatic cpu_op(input logic rw, input logic [15:0] a, input logic [7:0] d);
      bus.cpu_req   = 1'b1;
      bus.cpu_rw    = rw;
      bus.cpu_addr  = a;
      bus.cpu_wdata = rw ? 8'h00 : d;
      if (rw) exp_rd.push_back('{data: d, cyc: cyc + 1});
      else    exp_wr.push_back('{addr: a, data: d});
      @(posedge eclk); #1;
      bus.cpu_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5C;
      ereset        = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.cpu_rw    = 1'b1;
      bus.cpu_addr  = 16'h0;
      bus.cpu_wdata = 8'h0;
      bus.rx_data   = 8'h0;
      bus.rx_valid  = 1'b0;
      repeat (3) @(posedge eclk);
      #1;
      check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      ereset = 1'b0;
      @(posedge eclk); #1;

      // Go: release CPU and echo
      exp_tx.push_back(8'h47);
      send_byte(8'h47);
      drain("go");
      check("go_cpu_hold", 32'(bus.cpu_hold), 32'd0);

      // Block write of three bytes
      exp_wr.push_back('{addr: 16'h1234, data: 8'hAA});
      exp_wr.push_back('{addr: 16'h1235, data: 8'hBB});
      exp_wr.push_back('{addr: 16'h1236, data: 8'hCC});
      send_seq(8'h57, 8'h12, 8'h34, 8'h03);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
      drain("write3");

      // Hold: only honoured if the FSM went back to IDLE
      exp_tx.push_back(8'h48);
      send_byte(8'h48);
      drain("hold");
      check("hold_cpu_hold", 32'(bus.cpu_hold), 32'd1);

      // Read back with a stalling transmitter
      tx_rand = 1'b1;
      exp_tx.push_back(8'hAA); exp_tx.push_back(8'hBB); exp_tx.push_back(8'hCC);
      send_seq(8'h52, 8'h12, 8'h34, 8'h03);
      drain("read3");
      tx_rand = 1'b0;

      // Loader write pending under five back-to-back CPU cycles
      send_seq(8'h57, 8'h20, 8'h00, 8'h01);
      bus.rx_data  = 8'h5A;
      bus.rx_valid = 1'b1;
      @(posedge eclk); #1;
      bus.rx_valid = 1'b0;
      cpu_op(1'b1, 16'h1234, 8'hAA);
      cpu_op(1'b0, 16'h3000, 8'h77);
      cpu_op(1'b1, 16'h1235, 8'hBB);
      cpu_op(1'b0, 16'h3001, 8'h88);
      cpu_op(1'b1, 16'h3000, 8'h77);
      exp_wr.push_back('{addr: 16'h2000, data: 8'h5A});
      @(negedge eclk);
      check("arb_6th_we", 32'(bus.mem_we), 32'd1);
      check("arb_6th_addr", 32'(bus.mem_addr), 32'h2000);
      @(posedge eclk); #1;
      drain("arb");
      check("cpu_rdata_held", 32'(bus.cpu_rdata), 32'h77);

      // Address wrap on write
      exp_wr.push_back('{addr: 16'hFFFF, data: 8'h11});
      exp_wr.push_back('{addr: 16'h0000, data: 8'h22});
      send_seq(8'h57, 8'hFF, 8'hFF, 8'h02);
      send_byte(8'h11); send_byte(8'h22);
      drain("wrap");

      // Count byte 0 reads a full 256-byte block
      for (int i = 0; i < 256; i++) exp_tx.push_back(8'(16'h0010 + 16'(i)) ^ 8'h5C);
      send_seq(8'h52, 8'h00, 8'h10, 8'h00);
      drain("read256");
      exp_tx.push_back(8'h47);
      send_byte(8'h47);
      drain("go2");
      check("go2_cpu_hold", 32'(bus.cpu_hold), 32'd0);

      // Reset in the middle of a write command
      send_byte(8'h57); send_byte(8'h12);
      ereset = 1'b1;
      repeat (2) @(posedge eclk);
      #1;
      check("midrst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
      check("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
      ereset = 1'b0;
      @(posedge eclk); #1;
      exp_tx.push_back(8'h47);
      send_byte(8'h47);
      drain("go3");
      check("go3_cpu_hold", 32'(bus.cpu_hold), 32'd0);
      check("mem_1200_untouched", 32'(mem[16'h1200]), 32'(8'h00 ^ 8'h5C));

      check("left_wr", 32'(exp_wr.size()), 32'd0);
      check("left_tx", 32'(exp_tx.size()), 32'd0);
      check("left_rd", 32'(exp_rd.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
